// File: rtl/tia_audio_pkg.sv
// Shared types and constants for the TIA audio channel: tone-mode encoding,
// LFSR seed and tap indices, and the divide-by-3 / divide-by-31 counter limits.
package tia_audio_pkg;

  typedef enum logic [3:0] {
    AUDC_SET0     = 4'h0,
    AUDC_POLY4    = 4'h1,
    AUDC_DIV31_P4 = 4'h2,
    AUDC_P5_P4    = 4'h3,
    AUDC_DIV2A    = 4'h4,
    AUDC_DIV2B    = 4'h5,
    AUDC_DIV31A   = 4'h6,
    AUDC_POLY5A   = 4'h7,
    AUDC_POLY9    = 4'h8,
    AUDC_POLY5B   = 4'h9,
    AUDC_DIV31B   = 4'hA,
    AUDC_SET1     = 4'hB,
    AUDC_DIV6A    = 4'hC,
    AUDC_DIV6B    = 4'hD,
    AUDC_DIV93    = 4'hE,
    AUDC_P5_DIV3  = 4'hF
  } audc_mode_e;

  // Every LFSR reseeds to all-ones; narrower registers take the low bits.
  localparam logic [8:0] LFSR_SEED = '1;

  localparam int unsigned POLY4_W   = 4;
  localparam int unsigned POLY4_TAP = 1;
  localparam int unsigned POLY5_W   = 5;
  localparam int unsigned POLY5_TAP = 2;
  localparam int unsigned POLY9_W   = 9;
  localparam int unsigned POLY9_TAP = 4;

  localparam int unsigned DIV31_LEN  = 31;
  localparam int unsigned DIV31_HIGH = 18;
  localparam int unsigned DIV3_LEN   = 3;

endpackage

// File: rtl/tia_audio_lfsr.sv
// Right-shifting Fibonacci LFSR: new MSB = bit0 ^ bit[TAP], output is bit0.
// Synchronous reseed to all-ones; shifts only when advance is high.
module tia_audio_lfsr
  import tia_audio_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned TAP   = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic advance,
  output logic bit0
);

  logic [WIDTH-1:0] r_state;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= LFSR_SEED[WIDTH-1:0];
    end else if (advance) begin
      r_state <= {r_state[0] ^ r_state[TAP], r_state[WIDTH-1:1]};
    end
  end

  assign bit0 = r_state[0];

endmodule

// File: rtl/tia_audio_channel.sv
// One TIA audio channel: line-rate prescaler, AUDF divider, poly/div counters
// and AUDC waveform select. Define TIA_AUDIO_POLY9_EN to build the poly9 register.
module tia_audio_channel
  import tia_audio_pkg::*;
#(
  parameter int unsigned LINE_TICKS = 114
) (
  input  logic       MASTERCLK,
  input  logic       RES_n,
  input  logic [3:0] audc,
  input  logic [4:0] audf,
  input  logic [3:0] audv,
  output logic       AUD,
  output logic [3:0] level,
  output logic       tick
);

  localparam int unsigned PW = (LINE_TICKS > 1) ? $clog2(LINE_TICKS) : 1;

  logic [PW-1:0] r_presc;
  logic [4:0]    r_div;
  logic [1:0]    r_div3;
  logic [4:0]    r_div31;
  logic          r_aud;
  logic [3:0]    r_level;
  logic          r_tick;

  audc_mode_e w_mode;
  logic       w_tick_cond;
  logic       w_pulse;
  logic       w_div3_strobe;
  logic       w_p4_adv;
  logic       w_p5_adv;
  logic       w_div31_adv;
  logic       w_aud_nxt;
  logic       w_p4_b0;
  logic       w_p5_b0;
  logic       w_p9_b0;
  logic       w_lfsr_reset;

  assign w_mode        = audc_mode_e'(audc);
  assign w_tick_cond   = (r_presc == PW'(LINE_TICKS - 1));
  assign w_pulse       = w_tick_cond && (r_div >= audf);
  assign w_div3_strobe = w_pulse && (r_div3 == 2'(DIV3_LEN - 1));
  assign w_lfsr_reset  = ~RES_n;

  tia_audio_lfsr #(.WIDTH(POLY4_W), .TAP(POLY4_TAP)) u_poly4 (
    .clk     (MASTERCLK),
    .reset   (w_lfsr_reset),
    .advance (w_p4_adv),
    .bit0    (w_p4_b0)
  );

  tia_audio_lfsr #(.WIDTH(POLY5_W), .TAP(POLY5_TAP)) u_poly5 (
    .clk     (MASTERCLK),
    .reset   (w_lfsr_reset),
    .advance (w_p5_adv),
    .bit0    (w_p5_b0)
  );

`ifdef TIA_AUDIO_POLY9_EN
  tia_audio_lfsr #(.WIDTH(POLY9_W), .TAP(POLY9_TAP)) u_poly9 (
    .clk     (MASTERCLK),
    .reset   (w_lfsr_reset),
    .advance (w_pulse),
    .bit0    (w_p9_b0)
  );
`else
  // Mode 8 falls back to the poly5 output when poly9 is not built.
  assign w_p9_b0 = w_p5_b0;
`endif

  // AUD samples each LFSR's bit0 before the shift that the same pulse causes.
  always_comb begin
    w_p4_adv    = w_pulse;
    w_p5_adv    = w_pulse;
    w_div31_adv = 1'b0;
    w_aud_nxt   = r_aud;
    case (w_mode)
      AUDC_SET0, AUDC_SET1: begin
        if (w_pulse) w_aud_nxt = 1'b1;
      end
      AUDC_POLY4: begin
        if (w_pulse) w_aud_nxt = w_p4_b0;
      end
      AUDC_DIV31_P4: begin
        w_p4_adv    = w_pulse && (r_div31 == '0);
        w_div31_adv = w_pulse;
        if (w_pulse) w_aud_nxt = w_p4_b0;
      end
      AUDC_P5_P4: begin
        w_p4_adv = w_pulse && w_p5_b0;
        if (w_pulse) w_aud_nxt = w_p4_b0;
      end
      AUDC_DIV2A, AUDC_DIV2B: begin
        if (w_pulse) w_aud_nxt = ~r_aud;
      end
      AUDC_DIV31A, AUDC_DIV31B: begin
        w_div31_adv = w_pulse;
        if (w_pulse) w_aud_nxt = (r_div31 < 5'(DIV31_HIGH));
      end
      AUDC_DIV93: begin
        w_div31_adv = w_div3_strobe;
        if (w_pulse) w_aud_nxt = (r_div31 < 5'(DIV31_HIGH));
      end
      AUDC_POLY5A, AUDC_POLY5B: begin
        if (w_pulse) w_aud_nxt = w_p5_b0;
      end
      AUDC_POLY9: begin
        if (w_pulse) w_aud_nxt = w_p9_b0;
      end
      AUDC_DIV6A, AUDC_DIV6B: begin
        if (w_div3_strobe) w_aud_nxt = ~r_aud;
      end
      AUDC_P5_DIV3: begin
        w_p5_adv = w_div3_strobe;
        if (w_pulse) w_aud_nxt = w_p5_b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge MASTERCLK) begin
    if (!RES_n) begin
      r_presc <= '0;
      r_div   <= '0;
      r_div3  <= '0;
      r_div31 <= '0;
      r_aud   <= 1'b0;
      r_level <= '0;
      r_tick  <= 1'b0;
    end else begin
      r_presc <= w_tick_cond ? '0 : r_presc + 1'b1;
      if (w_tick_cond) begin
        r_div <= (r_div >= audf) ? '0 : r_div + 5'd1;
      end
      if (w_pulse) begin
        r_div3 <= (r_div3 == 2'(DIV3_LEN - 1)) ? '0 : r_div3 + 2'd1;
      end
      if (w_div31_adv) begin
        r_div31 <= (r_div31 == 5'(DIV31_LEN - 1)) ? '0 : r_div31 + 5'd1;
      end
      r_aud   <= w_aud_nxt;
      r_level <= w_aud_nxt ? audv : '0;
      r_tick  <= w_tick_cond;
    end
  end

  assign AUD   = r_aud;
  assign level = r_level;
  assign tick  = r_tick;

endmodule

// File: doc/tia_audio_channel.md
TIA_AUDIO_CHANNEL -- requirements
Module: tia_audio_channel

Interface
REQ-001 SHALL have a single parameter: LINE_TICKS, default 114, giving MASTERCLK cycles per audio tick (two ticks per 228-clock scanline).
REQ-002 SHALL have these ports, clock and reset first:
- MASTERCLK, input, 1: 3.58 MHz pixel clock.
- RES_n, input, 1: reset.
- audc, input, 4: AUDCx control (tone mode).
- audf, input, 5: AUDFx frequency divider.
- audv, input, 4: AUDVx volume.
- AUD, output, 1: channel waveform bit.
- level, output, 4: AUD ? audv : 0.
- tick, output, 1: one-cycle audio-tick strobe.
REQ-003 One clock; reset is synchronous and active-low.

Function
REQ-004 The prescaler SHALL count 0..LINE_TICKS-1 and wrap; tick=1 in the cycle the prescaler equals LINE_TICKS-1.
REQ-005 On each tick, the 5-bit divider SHALL be compared with audf; if divider>=audf it clears to 0 and asserts an internal pulse, otherwise it increments. With audf=N, pulses occur every N+1 ticks.
REQ-006 audc, audf and audv SHALL be sampled live; a change takes effect at the next tick. If divider>audf after audf is lowered, the divider clears and pulses on the next tick.
REQ-007 poly4: x^4+x^3+1, shift right, new MSB = b0^b1, output b0. poly5: x^5+x^3+1, new MSB = b0^b2. poly9: x^9+x^5+1, new MSB = b0^b4. Each LFSR SHALL advance only on a pulse.
REQ-008 div3 (0..2) SHALL advance on every pulse; "div3 strobe" is a pulse with div3==2. div31 (0..30) SHALL advance on every pulse in modes 2, 6 and A, and on every div3 strobe in mode E.
REQ-009 On a pulse, AUD SHALL update per audc:
- 0, B: AUD=1.
- 1: AUD=poly4.b0.
- 2: poly4 advances only when div31==0; AUD=poly4.b0.
- 3: poly4 advances only when poly5.b0==1; AUD=poly4.b0.
- 4, 5: AUD toggles.
- 6, A, E: AUD=1 while div31<18, else 0.
- 7, 9: AUD=poly5.b0.
- 8: AUD=poly9.b0.
- C, D: AUD toggles on div3 strobe.
- F: poly5 advances only on div3 strobe; AUD=poly5.b0.
REQ-010 AUD, level and tick SHALL be registered and update one cycle after the tick/pulse condition. level SHALL also track audv changes on the next cycle with no tick required.
REQ-011 An audc change SHALL NOT reset any LFSR or counter; state carries across mode switches.

Reset
REQ-012 While RES_n=0 at a MASTERCLK edge: prescaler=0, divider=0, div3=0, div31=0, all LFSRs all-ones, AUD=0, level=0, tick=0.
REQ-013 Reset asserted mid-tone SHALL abort the waveform immediately. The first tick after release SHALL occur LINE_TICKS cycles after release.

Configuration
REQ-014 With macro TIA_AUDIO_POLY9_EN defined, the poly9 register SHALL exist and mode 8 SHALL output poly9. Without it, poly9 SHALL be absent and mode 8 SHALL behave exactly as mode 7.

Structure
REQ-015 Package tia_audio_pkg SHALL hold the audc mode enum, LFSR seeds, tap indices, and the constants 31, 18 and 3.
REQ-016 Sub-module tia_audio_lfsr (parameters WIDTH, TAP; ports advance, reset, bit0) SHALL be instantiated for poly4, poly5 and poly9.

Verification
REQ-017 audc=4, audf=0, audv=F: AUD toggles every 114 clocks; level alternates F/0.
REQ-018 audc=4, audf=3: AUD toggles every 456 clocks. Changing audf to 0 while divider=2: pulse on the next tick.
REQ-019 audc=1, audf=0 from reset: AUD sequence 1,1,1,1,0,0,0,1,0,0,1,1,0,1,0 then repeats (period 15 pulses).
REQ-020 audc=C, audf=0: AUD toggles every 342 clocks. audc=6, audf=0: 18 ticks high, 13 ticks low, period 31.
REQ-021 audc=0, audv=7: AUD=1 after the first tick, level=7. Writing audv=2 gives level=2 the next cycle.
REQ-022 RES_n low for 1 cycle mid-tone: AUD=0 and level=0 next cycle; LFSRs reseed; first tick 114 clocks after release. Run both with and without TIA_AUDIO_POLY9_EN for audc=8.
